mc_ctrl_fsm: RTL

//  Multi-cycle sequencer for the MIPS datapath. Steps each instruction through FETCH/DECODE/EXEC/MEM/WB.

---
 rtl/mc_ctrl_fsm_if.sv | 33 +++
 rtl/mc_ctrl_fsm.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_fsm_if.sv
// Control/status bundle between the multi-cycle sequencer (master) and the
// datapath plus memory side (slave).
interface mc_ctrl_fsm_if #(
   parameter int CNT_W = 32
);
   logic [5:0]       opcode;
   logic [5:0]       funct;
   logic             br_cond;
   logic             imem_ack;
   logic             dmem_ack;
   logic [2:0]       state;
   logic             imem_req;
   logic             dmem_req;
   logic             dmem_we;
   logic             ir_we;
   logic             pc_we;
   logic [1:0]       pc_sel;
   logic             reg_we;
   logic             illegal;
   logic [CNT_W-1:0] retired;

   modport master (
      input  opcode, funct, br_cond, imem_ack, dmem_ack,
      output state, imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel,
             reg_we, illegal, retired
   );

   modport slave (
      output opcode, funct, br_cond, imem_ack, dmem_ack,
      input  state, imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel,
             reg_we, illegal, retired
   );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS sequencer: walks each instruction through FETCH/DECODE/
// EXEC/MEM/WB, issues datapath enables and counts retired instructions.
module mc_ctrl_fsm #(
   parameter int CNT_W = 32
) (
   input  logic          clk,
   input  logic          reset,
   mc_ctrl_fsm_if.master bus
);
   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00, OP_J   = 6'h02, OP_JAL = 6'h03,
                          OP_BEQ   = 6'h04, OP_BNE = 6'h05, OP_BGTZ = 6'h07,
                          OP_ORI   = 6'h0d, OP_LUI = 6'h0f,
                          OP_LB    = 6'h20, OP_LH  = 6'h21, OP_LW  = 6'h23,
                          OP_SB    = 6'h28, OP_SH  = 6'h29, OP_SW  = 6'h2b;
   localparam logic [5:0] F_SLL = 6'h00, F_SLLV = 6'h04, F_JR  = 6'h08,
                          F_JALR = 6'h09, F_ADD = 6'h20, F_SUB = 6'h22,
                          F_SLT = 6'h2a, F_SLTU = 6'h2b;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] retired_q, retired_d;

   logic is_rtype, is_alu, is_jr, is_jalr, is_j, is_jal, is_br;
   logic is_load, is_store, supported;

   always_comb begin
      is_rtype  = (bus.opcode == OP_RTYPE);
      is_alu    = (is_rtype && (bus.funct inside {F_ADD, F_SUB, F_SLL, F_SLLV, F_SLT, F_SLTU}))
                  || (bus.opcode == OP_LUI) || (bus.opcode == OP_ORI);
      is_jr     = is_rtype && (bus.funct == F_JR);
      is_jalr   = is_rtype && (bus.funct == F_JALR);
      is_j      = (bus.opcode == OP_J);
      is_jal    = (bus.opcode == OP_JAL);
      is_br     = bus.opcode inside {OP_BEQ, OP_BNE, OP_BGTZ};
      is_load   = bus.opcode inside {OP_LW, OP_LH, OP_LB};
      is_store  = bus.opcode inside {OP_SW, OP_SH, OP_SB};
      supported = is_alu | is_jr | is_jalr | is_j | is_jal | is_br | is_load | is_store;
   end

   logic       imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we, illegal, retire;
   logic [1:0] pc_sel;

   always_comb begin
      state_d  = state_q;
      retire   = 1'b0;
      imem_req = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      ir_we    = 1'b0;
      pc_we    = 1'b0;
      pc_sel   = 2'b00;
      reg_we   = 1'b0;
      illegal  = 1'b0;
      case (state_q)
         S_FETCH: begin
            imem_req = 1'b1;
            if (bus.imem_ack) begin
               ir_we   = 1'b1;
               pc_we   = 1'b1;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            if (supported) begin
               state_d = S_EXEC;
            end else begin
               illegal = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_EXEC: begin
            if (is_br) begin
               pc_we   = bus.br_cond;
               pc_sel  = 2'b01;
               state_d = S_FETCH;
               retire  = 1'b1;
            end else if (is_j || is_jr) begin
               pc_we   = 1'b1;
               pc_sel  = is_j ? 2'b10 : 2'b11;
               state_d = S_FETCH;
               retire  = 1'b1;
            end else if (is_jal || is_jalr) begin
               // Link value (PC+4) was already captured in FETCH, so the
               // PC can be overwritten here before WB writes the link.
               pc_we   = 1'b1;
               pc_sel  = is_jal ? 2'b10 : 2'b11;
               state_d = S_WB;
            end else if (is_load || is_store) begin
               state_d = S_MEM;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = is_store;
            if (bus.dmem_ack) begin
               state_d = is_store ? S_FETCH : S_WB;
               retire  = is_store;
            end
         end
         S_WB: begin
            reg_we  = 1'b1;
            state_d = S_FETCH;
            retire  = 1'b1;
         end
         default: state_d = S_FETCH;
      endcase
   end

   always_comb begin
      retired_d = retired_q;
      if (retire) retired_d = retired_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_FETCH;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         retired_q <= retired_d;
      end
   end

   // Strobes are forced low for the whole time reset is held, not just at edges.
   assign bus.state    = state_q;
   assign bus.imem_req = imem_req & ~reset;
   assign bus.dmem_req = dmem_req & ~reset;
   assign bus.dmem_we  = dmem_we  & ~reset;
   assign bus.ir_we    = ir_we    & ~reset;
   assign bus.pc_we    = pc_we    & ~reset;
   assign bus.pc_sel   = reset ? 2'b00 : pc_sel;
   assign bus.reg_we   = reg_we   & ~reset;
   assign bus.illegal  = illegal  & ~reset;
   assign bus.retired  = retired_q;
endmodule
